// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and helpers for the output source switch
//
// Purpose: switch state encoding, the frame-start primitive and the frame
//          length assumed by the modulator/silencer chain.
// Ports:   none (package).

package switch_pkg;

    // Beats (transducers) per frame. The switch needs no counter because it
    // only ever changes source on frame starts; the value is kept here so
    // stimulus and downstream blocks share one definition.
    localparam int DEPTH = 249;

    typedef enum logic [1:0] {
        ACTIVE      = 2'd0,
        WAIT_FINISH = 2'd1,
        WAIT_START  = 2'd2
    } switch_state_t;

    // A frame begins on the first valid beat after an idle cycle.
    function automatic logic frame_start(input logic valid, input logic valid_prev);
        return valid & ~valid_prev;
    endfunction

endpackage

// File: rtl/output_source_switch_if.sv
// rtl/output_source_switch_if.sv - source streams, switch control and selected output
//
// Purpose: bundles every per-source stream, the controller's switch request
//          and gating controls, and the selected output stream.
// Ports:   DUTY_IN/PHASE_IN/DIN_VALID/IDX_IN  per-source streams (packed by source)
//          REQ_SRC, USE_START_IDX, START_IDX, USE_FINISH_IDX, FINISH_IDX  control
//          DUTY/PHASE/DOUT_VALID  selected stream; CUR_SRC, PENDING  status
// Modports: master = sources + controller side, slave = switch side.

interface output_source_switch_if #(
    parameter int WIDTH   = 13,
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 16,
    parameter int SRC_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0][WIDTH-1:0] DUTY_IN;
    logic [NUM_SRC-1:0][WIDTH-1:0] PHASE_IN;
    logic [NUM_SRC-1:0]            DIN_VALID;
    logic [NUM_SRC-1:0][IDX_W-1:0] IDX_IN;
    logic [SRC_W-1:0]              REQ_SRC;
    logic                          USE_START_IDX;
    logic [IDX_W-1:0]              START_IDX;
    logic                          USE_FINISH_IDX;
    logic [IDX_W-1:0]              FINISH_IDX;
    logic [WIDTH-1:0]              DUTY;
    logic [WIDTH-1:0]              PHASE;
    logic                          DOUT_VALID;
    logic [SRC_W-1:0]              CUR_SRC;
    logic                          PENDING;

    modport master (
        output DUTY_IN, PHASE_IN, DIN_VALID, IDX_IN,
        output REQ_SRC, USE_START_IDX, START_IDX, USE_FINISH_IDX, FINISH_IDX,
        input  DUTY, PHASE, DOUT_VALID, CUR_SRC, PENDING
    );

    modport slave (
        input  DUTY_IN, PHASE_IN, DIN_VALID, IDX_IN,
        input  REQ_SRC, USE_START_IDX, START_IDX, USE_FINISH_IDX, FINISH_IDX,
        output DUTY, PHASE, DOUT_VALID, CUR_SRC, PENDING
    );

endinterface

// File: rtl/frame_start_detect.sv
// rtl/frame_start_detect.sv - rising-edge detector on one source's beat valid
//
// Purpose: flags the first beat of each frame of a single source.
// Ports:   clk_i, rst_n_i (async active-low)
//          valid_i  source beat valid
//          start_o  high on the frame's first beat (combinational from valid_i)

module frame_start_detect
    import switch_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic valid_i,
    output logic start_o
);

    logic valid_prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_prev_q <= 1'b0;
        end else begin
            valid_prev_q <= valid_i;
        end
    end

    // Combinational so the switch can commit on the very beat the frame opens.
    assign start_o = frame_start(valid_i, valid_prev_q);

endmodule

// File: rtl/output_source_switch.sv
// rtl/output_source_switch.sv - frame-aligned N-way drive-data source selector
//
// Purpose: passes one of NUM_SRC duty/phase streams (0 = normal operator,
//          others = STM operators) to the modulator chain, changing source only
//          on frame starts with optional finish/start index gating.
// Ports:   CLK, RESET_N (async active-low)
//          bus (slave)  per-source streams and control in; selected stream,
//                       CUR_SRC and PENDING out. Output latency is one cycle.

module output_source_switch
    import switch_pkg::*;
#(
    parameter int WIDTH   = 13,
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 16,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    output_source_switch_if.slave bus
);

    localparam int SRC_SPAN = 1 << SRC_W;

    logic [NUM_SRC-1:0]  fs;
    logic [SRC_SPAN-1:0] src_ok;
    logic [SRC_W-1:0]    req_eff;

    switch_state_t    state_q, state_d;
    logic [SRC_W-1:0] cur_q, cur_d;
    logic [SRC_W-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] duty_q, phase_q;
    logic             valid_q;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fsd
        frame_start_detect u_fsd (
            .clk_i   (CLK),
            .rst_n_i (RESET_N),
            .valid_i (bus.DIN_VALID[k]),
            .start_o (fs[k])
        );
    end

    // Selector codes that name no source are folded onto CUR_SRC, which makes
    // them indistinguishable from "no change requested".
    always_comb begin
        for (int i = 0; i < SRC_SPAN; i++) begin
            src_ok[i] = (i < NUM_SRC);
        end
    end

    assign req_eff = src_ok[bus.REQ_SRC] ? bus.REQ_SRC : cur_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        case (state_q)
            ACTIVE: begin
                if (req_eff != cur_q) begin
                    tgt_d   = req_eff;
                    state_d = bus.USE_FINISH_IDX ? WAIT_FINISH : WAIT_START;
                end
            end
            WAIT_FINISH, WAIT_START: begin
                // Request changes outrank any frame event in the same cycle.
                if (req_eff == cur_q) begin
                    state_d = ACTIVE;
                end else if (req_eff != tgt_q) begin
                    tgt_d = req_eff;
                end else if (state_q == WAIT_FINISH) begin
                    // Finishing never commits in the same cycle, even if the
                    // target opens a frame now; the commit waits for the next.
                    if (fs[cur_q] && (bus.IDX_IN[cur_q] == bus.FINISH_IDX)) begin
                        state_d = WAIT_START;
                    end
                end else if (fs[tgt_q] &&
                             (!bus.USE_START_IDX || (bus.IDX_IN[tgt_q] == bus.START_IDX))) begin
                    cur_d   = tgt_q;
                    state_d = ACTIVE;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ACTIVE;
            cur_q   <= '0;
            tgt_q   <= '0;
            duty_q  <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            // Selecting with cur_d lets a commit on a frame-start beat carry
            // that whole frame from the new source.
            duty_q  <= bus.DUTY_IN[cur_d];
            phase_q <= bus.PHASE_IN[cur_d];
            valid_q <= bus.DIN_VALID[cur_d];
        end
    end

    assign bus.DUTY       = duty_q;
    assign bus.PHASE      = phase_q;
    assign bus.DOUT_VALID = valid_q;
    assign bus.CUR_SRC    = cur_q;
    assign bus.PENDING    = (state_q != ACTIVE);

endmodule

// File: tb/tb_output_source_switch.sv
// tb/tb_output_source_switch.sv - self-checking bench for output_source_switch

module tb_output_source_switch;
    import switch_pkg::*;

    localparam int W   = 13;
    localparam int NS  = 4;
    localparam int IW  = 16;
    localparam int SW  = 2;
    localparam int GAP = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    output_source_switch_if #(.WIDTH(W), .NUM_SRC(NS), .IDX_W(IW)) bus ();
    output_source_switch_if #(.WIDTH(W), .NUM_SRC(3),  .IDX_W(IW)) bus3 ();

    output_source_switch #(.WIDTH(W), .NUM_SRC(NS), .IDX_W(IW)) dut (
        .CLK(clk), .RESET_N(rst_n), .bus(bus)
    );
    output_source_switch #(.WIDTH(W), .NUM_SRC(3), .IDX_W(IW)) dut3 (
        .CLK(clk), .RESET_N(rst_n), .bus(bus3)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level reference: which source owns each frame, decided from the
    // request history and the indices every source presents at frame start.
    int          m_cur, m_tgt;
    bit          m_pend, m_fin_ok;
    int          idx_ctr [NS];
    int          idx_mod [NS];
    logic [IW-1:0] idx_val [NS];
    logic [W-1:0] exp_duty, exp_phase;
    logic         exp_valid;
    bit           rst_drv;

    task automatic model_req(input int r);
        bus.REQ_SRC = SW'(r);
        if (r >= NS || r == m_cur) begin
            m_pend = 1'b0;
        end else if (!m_pend) begin
            m_pend   = 1'b1;
            m_tgt    = r;
            m_fin_ok = !bus.USE_FINISH_IDX;
        end else begin
            m_tgt = r;
        end
    endtask

    task automatic model_frame_start();
        if (m_pend) begin
            if (!m_fin_ok) begin
                if (idx_val[m_cur] == bus.FINISH_IDX) m_fin_ok = 1'b1;
            end else if (!bus.USE_START_IDX || idx_val[m_tgt] == bus.START_IDX) begin
                m_cur  = m_tgt;
                m_pend = 1'b0;
            end
        end
    endtask

    // One cycle: check last cycle's outputs, then drive this cycle's inputs.
    task automatic step(input logic v, input bit fs, input int r);
        @(negedge clk);
        checks++;
        if ({bus.DOUT_VALID, bus.DUTY, bus.PHASE} !== {exp_valid, exp_duty, exp_phase}) begin
            errors++;
            $display("FAIL data t=%0t got v=%0b d=%0h p=%0h want v=%0b d=%0h p=%0h",
                     $time, bus.DOUT_VALID, bus.DUTY, bus.PHASE, exp_valid, exp_duty, exp_phase);
        end
        checks++;
        if (bus.CUR_SRC !== SW'(m_cur)) begin
            errors++;
            $display("FAIL cur_src t=%0t got %0d want %0d", $time, bus.CUR_SRC, m_cur);
        end
        checks++;
        if (bus.PENDING !== m_pend) begin
            errors++;
            $display("FAIL pending t=%0t got %0b want %0b", $time, bus.PENDING, m_pend);
        end
        rst_n = rst_drv;
        for (int k = 0; k < NS; k++) begin
            bus.DUTY_IN[k]  = W'($urandom);
            bus.PHASE_IN[k] = W'($urandom);
            if (fs) begin
                idx_val[k] = IW'(idx_ctr[k]);
                idx_ctr[k] = (idx_ctr[k] + 1) % idx_mod[k];
                bus.IDX_IN[k] = idx_val[k];
            end
        end
        bus.DIN_VALID  = {NS{v}};
        bus3.DIN_VALID = {3{v}};
        if (r >= 0) model_req(r);
        if (fs && rst_drv) model_frame_start();
        if (rst_drv) begin
            exp_duty  = bus.DUTY_IN[m_cur];
            exp_phase = bus.PHASE_IN[m_cur];
            exp_valid = v;
        end else begin
            exp_duty  = '0;
            exp_phase = '0;
            exp_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input int ra, input int ba, input int rb, input int bb);
        for (int b = 0; b < DEPTH; b++) begin
            step(1'b1, b == 0, (b == ba) ? ra : ((b == bb) ? rb : -1));
        end
        for (int g = 0; g < GAP; g++) step(1'b0, 1'b0, -1);
    endtask

    task automatic set_gate(input bit uf, input int fi, input bit us, input int si);
        bus.USE_FINISH_IDX = uf;
        bus.FINISH_IDX     = IW'(fi);
        bus.USE_START_IDX  = us;
        bus.START_IDX      = IW'(si);
    endtask

    task automatic test_reset();
        rst_drv = 1'b1;
        run_frame(-1, -1, -1, -1);
        for (int b = 0; b < 60; b++) step(1'b1, b == 0, -1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.DOUT_VALID, bus.DUTY, bus.PHASE, bus.CUR_SRC, bus.PENDING} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%0b d=%0h p=%0h cur=%0d pend=%0b want all 0",
                     bus.DOUT_VALID, bus.DUTY, bus.PHASE, bus.CUR_SRC, bus.PENDING);
        end
        rst_drv   = 1'b0;
        m_cur     = 0;
        m_tgt     = 0;
        m_pend    = 1'b0;
        exp_duty  = '0;
        exp_phase = '0;
        exp_valid = 1'b0;
        for (int b = 60; b < 64; b++) step(1'b1, 1'b0, -1);
        rst_drv = 1'b1;
        for (int b = 64; b < DEPTH; b++) step(1'b1, 1'b0, -1);
        for (int g = 0; g < GAP; g++) step(1'b0, 1'b0, -1);
    endtask

    task automatic test_switch_ungated();
        set_gate(0, 0, 0, 0);
        run_frame(2, 100, -1, -1);
        run_frame(-1, -1, -1, -1);
        run_frame(-1, -1, -1, -1);
    endtask

    task automatic test_finish_gate();
        run_frame(1, 100, -1, -1);
        run_frame(-1, -1, -1, -1);
        idx_mod[1] = 10;
        idx_ctr[1] = 0;
        set_gate(1, 5, 0, 0);
        run_frame(-1, -1, -1, -1);
        run_frame(-1, -1, -1, -1);
        run_frame(0, 100, -1, -1);
        for (int f = 0; f < 5; f++) run_frame(-1, -1, -1, -1);
    endtask

    task automatic test_start_gate();
        idx_mod[3] = 8;
        idx_ctr[3] = 0;
        set_gate(0, 0, 1, 3);
        run_frame(3, 120, -1, -1);
        for (int f = 0; f < 5; f++) run_frame(-1, -1, -1, -1);
    endtask

    task automatic test_abort();
        idx_mod[1] = 8;
        idx_ctr[1] = 5;
        set_gate(0, 0, 1, 3);
        run_frame(1, 50, -1, -1);
        run_frame(3, 120, -1, -1);
        run_frame(-1, -1, -1, -1);
    endtask

    task automatic test_retarget();
        set_gate(0, 0, 0, 0);
        run_frame(0, 100, -1, -1);
        run_frame(-1, -1, -1, -1);
        idx_mod[1] = 8;
        idx_ctr[1] = 4;
        idx_mod[3] = 8;
        idx_ctr[3] = 0;
        set_gate(0, 0, 1, 3);
        run_frame(1, 80, -1, -1);
        run_frame(3, 80, -1, -1);
        for (int f = 0; f < 4; f++) run_frame(-1, -1, -1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < NS; k++) begin
            idx_mod[k] = 4;
            idx_ctr[k] = $urandom_range(0, 3);
        end
        for (int f = 0; f < 12; f++) begin
            if (!m_pend) begin
                set_gate($urandom_range(0, 1), $urandom_range(0, 3),
                         $urandom_range(0, 1), $urandom_range(0, 3));
            end
            run_frame($urandom_range(0, NS - 1), $urandom_range(1, 120),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, NS - 1) : -1,
                      $urandom_range(121, DEPTH - 1));
        end
    endtask

    task automatic test_out_of_range();
        bus3.REQ_SRC = 2'd3;
        run_frame(-1, -1, -1, -1);
        run_frame(-1, -1, -1, -1);
        checks++;
        if (bus3.CUR_SRC !== 2'd0 || bus3.PENDING !== 1'b0) begin
            errors++;
            $display("FAIL oor_ignored got cur=%0d pend=%0b want cur=0 pend=0",
                     bus3.CUR_SRC, bus3.PENDING);
        end
        bus3.REQ_SRC = 2'd2;
        run_frame(-1, -1, -1, -1);
        run_frame(-1, -1, -1, -1);
        checks++;
        if (bus3.CUR_SRC !== 2'd2 || bus3.PENDING !== 1'b0) begin
            errors++;
            $display("FAIL oor_then_valid got cur=%0d pend=%0b want cur=2 pend=0",
                     bus3.CUR_SRC, bus3.PENDING);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rst_drv   = 1'b0;
        m_cur     = 0;
        m_tgt     = 0;
        m_pend    = 1'b0;
        m_fin_ok  = 1'b0;
        exp_duty  = '0;
        exp_phase = '0;
        exp_valid = 1'b0;
        for (int k = 0; k < NS; k++) begin
            idx_mod[k] = 1;
            idx_ctr[k] = 0;
            idx_val[k] = '0;
        end
        bus.DUTY_IN   = '0;
        bus.PHASE_IN  = '0;
        bus.DIN_VALID = '0;
        bus.IDX_IN    = '0;
        bus.REQ_SRC   = '0;
        set_gate(0, 0, 0, 0);
        bus3.DUTY_IN        = '0;
        bus3.PHASE_IN       = '0;
        bus3.DIN_VALID      = '0;
        bus3.IDX_IN         = '0;
        bus3.REQ_SRC        = '0;
        bus3.USE_START_IDX  = 1'b0;
        bus3.START_IDX      = '0;
        bus3.USE_FINISH_IDX = 1'b0;
        bus3.FINISH_IDX     = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, -1);

        test_reset();
        test_switch_ungated();
        test_finish_gate();
        test_start_gate();
        test_abort();
        test_retarget();
        test_random();
        test_out_of_range();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
